aixh_mxc_mac_seq: RTL and testbench
===================================

# aixh_mxc_mac_seq

MAC/drain sequencer for the MxConv array. It takes one job descriptor: accumulation depth K, tile count T and MAC mode. For each tile it issues one accumulator-refresh command, K operand-gated MAC-enable commands and one backpressured drain request, then holds a fixed gap before the next tile. It sits between the DCS-fed controller and the upper/corner command inputs (`mac_afresh`, `mac_enable`, `mac_mode`, `drain_req`).

## Interface
Parameters:
- `KCNT_BITS`, 16: width of the K count.
- `TCNT_BITS`, 16: width of the tile count.
- `DRAIN_GAP`, 4: idle cycles after each drain, range 0..15.

Ports:
- `aixh_core_clk2x` in 1: sole clock.
- `aixh_core_rst` in 1: reset, synchronous, active-high.
- `i_start` in 1: job request; accepted only when `o_ready`=1.
- `i_kcnt` in `KCNT_BITS`: MAC steps per tile; 0 is illegal.
- `i_tcnt` in `TCNT_BITS`: tiles per job; 0 is illegal.
- `i_mode` in 3: {int8, shift[1:0]}; legal values are 000, 001, 010, 100, 101, 110.
- `i_opnd_vld` in 1: operands for one MAC step are available.
- `i_drain_rdy` in 1: downstream accepts a drain this cycle.
- `o_ready` out 1: idle and able to accept a job.
- `o_mac_afresh` out 1: accumulator refresh.
- `o_mac_enable` out 1: MAC step.
- `o_opnd_pop` out 1: operand consumed; identical to `o_mac_enable`.
- `o_mac_mode` out 3: latched mode of the current job.
- `o_drain_req` out 1: drain request.
- `o_tile_idx` out `TCNT_BITS`: index of the tile in flight.
- `o_done` out 1: one-cycle pulse at job end.
- `o_err` out 1: one-cycle pulse when a job is rejected.

## Operation
- State machine states: IDLE, FRESH, MAC, DRAIN, GAP, DONE.
- IDLE:
  - `o_ready`=1.
  - `i_start` with legal K, T and mode: latch all three, clear `o_tile_idx`, go to FRESH.
  - `i_start` with any illegal field: set `o_err`=1 for the next cycle and stay in IDLE.
- FRESH: `o_mac_afresh`=1 for exactly one cycle, load the K counter, go to MAC. Refresh never coincides with enable, because refresh has priority over enable downstream.
- MAC:
  - `o_mac_enable` = `o_opnd_pop` = `i_opnd_vld` (combinational).
  - The K counter decrements on each enable.
  - Leave for DRAIN in the cycle after the K-th enable.
- DRAIN:
  - `o_drain_req` = `i_drain_rdy` (combinational).
  - On the first cycle with `i_drain_rdy`=1, go to GAP, or directly to next-tile/DONE when `DRAIN_GAP`=0.
- GAP:
  - Hold for `DRAIN_GAP` cycles.
  - Then, if `o_tile_idx`==T-1, go to DONE.
  - Otherwise increment `o_tile_idx` and go to FRESH.
- DONE: `o_done`=1 for one cycle, go to IDLE.
- `i_start` outside IDLE is ignored; no error is flagged.
- `o_mac_mode` holds the latched value from acceptance until the next accepted job.
- Counter wrap: K and T may be as large as 2^width−1; counters are down-counters with a zero flag and never wrap.

## Timing
- Reset (aixh_core_rst=1 at a clock edge):
  - State goes to IDLE and all counters clear.
  - After that edge: `o_ready`=1; `o_tile_idx`=0; `o_mac_mode`=0.
  - All other outputs are 0.
- Reset mid-job aborts the job immediately. No drain and no `o_done` are issued.
- Start is sampled at edge n; FRESH (`o_mac_afresh`=1) is visible in cycle n+1.
- Minimum cycles per tile: 1 + K + 1 + `DRAIN_GAP`. Stall cycles on `i_opnd_vld` and `i_drain_rdy` add one cycle each.
- `o_done` is asserted one cycle after the last GAP cycle. `o_ready` rises the following cycle, and a new start may be sampled in that cycle.
- `o_err` is asserted in cycle n+1 for a rejected start at edge n; `o_ready` stays 1 throughout.
- `o_mac_enable`, `o_opnd_pop` and `o_drain_req` are the only combinationally driven outputs (state register AND input). All other outputs decode directly from registered state.

## Structure
- Add to `AIXH_MXC_pkg`:
  - the state enum typedef `MXC_SEQ_State`;
  - the legal-mode function `mxc_mode_legal()`;
  - the six legal mode constants, shared with the corner bias logic.
- Sub-module `aixh_mxc_seq_cnt`: loadable down-counter with a zero flag, parameterized width. It is instantiated three times, for K, T and gap.

## Test plan
- Baseline: K=3, T=2, mode=100, `DRAIN_GAP`=4, opnd_vld=drain_rdy=1, start at edge 0. Required response:
  - afresh in cycles 1 and 10;
  - enable in cycles 2–4 and 11–13;
  - drain_req in cycles 5 and 14;
  - `o_tile_idx`=1 from cycle 10;
  - done in cycle 19, ready in cycle 20.
- Operand stall: K=2, opnd_vld=0,1,0,0,1 from cycle 2. Required response: enables only in cycles 3 and 6, exactly 2 pops, drain in cycle 7.
- Drain backpressure: drain_rdy=0 for 3 cycles while in DRAIN. Required response: drain_req stays 0 during that time, then exactly one pulse in the first cycle with rdy=1.
- Rejects: start with kcnt=0, then tcnt=0, then mode=011. Required response: `o_err` pulse the next cycle in each case, no afresh, `o_ready` held at 1.
- Start while busy is ignored; `DRAIN_GAP`=0 gives back-to-back tiles with drain followed immediately by afresh.
- Reset asserted in the MAC phase for 1 cycle. Required response:
  - all outputs at reset values on the next cycle;
  - no done pulse;
  - a subsequent job with K=1, T=1 completes in 1+1+1+`DRAIN_GAP`+1 cycles.

Source files
------------

// File: rtl/aixh_mxc_pkg.sv
// Shared MxConv types: sequencer state encoding and the legal MAC modes.
// The mode constants are also consumed by the corner bias logic.
package AIXH_MXC_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_FRESH,
    SEQ_MAC,
    SEQ_DRAIN,
    SEQ_GAP,
    SEQ_DONE
  } MXC_SEQ_State;

  // {int8, shift[1:0]}; shift code 2'b11 is unused
  localparam logic [2:0] MXC_MODE_S0    = 3'b000;
  localparam logic [2:0] MXC_MODE_S1    = 3'b001;
  localparam logic [2:0] MXC_MODE_S2    = 3'b010;
  localparam logic [2:0] MXC_MODE_I8_S0 = 3'b100;
  localparam logic [2:0] MXC_MODE_I8_S1 = 3'b101;
  localparam logic [2:0] MXC_MODE_I8_S2 = 3'b110;

  function automatic logic mxc_mode_legal(input logic [2:0] mode);
    logic ok;
    ok = 1'b0;
    unique case (mode)
      MXC_MODE_S0,
      MXC_MODE_S1,
      MXC_MODE_S2,
      MXC_MODE_I8_S0,
      MXC_MODE_I8_S1,
      MXC_MODE_I8_S2: ok = 1'b1;
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/aixh_mxc_mac_seq_cnt.sv
// Loadable down-counter with a zero flag; saturates at zero.
// Instantiated for the K, tile and drain-gap counts.
module aixh_mxc_seq_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/aixh_mxc_mac_seq.sv
// MAC/drain sequencer: per tile one refresh, K gated MAC steps,
// one backpressured drain and a fixed idle gap.
module aixh_mxc_mac_seq
  import AIXH_MXC_pkg::*;
#(
  parameter int KCNT_BITS = 16,
  parameter int TCNT_BITS = 16,
  parameter int DRAIN_GAP = 4
) (
  input  logic                 aixh_core_clk2x,
  input  logic                 aixh_core_rst,
  input  logic                 i_start,
  input  logic [KCNT_BITS-1:0] i_kcnt,
  input  logic [TCNT_BITS-1:0] i_tcnt,
  input  logic [2:0]           i_mode,
  input  logic                 i_opnd_vld,
  input  logic                 i_drain_rdy,
  output logic                 o_ready,
  output logic                 o_mac_afresh,
  output logic                 o_mac_enable,
  output logic                 o_opnd_pop,
  output logic [2:0]           o_mac_mode,
  output logic                 o_drain_req,
  output logic [TCNT_BITS-1:0] o_tile_idx,
  output logic                 o_done,
  output logic                 o_err
);

  localparam int GAP_LD = (DRAIN_GAP > 0) ? DRAIN_GAP - 1 : 0;

  MXC_SEQ_State         state;
  logic [KCNT_BITS-1:0] k_lat;
  logic [TCNT_BITS-1:0] tile;
  logic [2:0]           mode;
  logic                 err;

  logic legal;
  logic accept;
  logic mac_fire;
  logic drain_fire;
  logic tile_end;
  logic k_zero;
  logic t_zero;
  logic g_zero;

  assign legal      = (i_kcnt != '0) && (i_tcnt != '0)
                    && mxc_mode_legal(i_mode);
  assign accept     = (state == SEQ_IDLE) && i_start && legal;
  assign mac_fire   = (state == SEQ_MAC) && i_opnd_vld;
  assign drain_fire = (state == SEQ_DRAIN) && i_drain_rdy;

  // With no gap configured the tile ends on the accepted drain itself
  assign tile_end = (DRAIN_GAP == 0) ? drain_fire
                  : ((state == SEQ_GAP) && g_zero);

  aixh_mxc_seq_cnt #(.W(KCNT_BITS)) u_kcnt (
    .clk      (aixh_core_clk2x),
    .rst      (aixh_core_rst),
    .load     (state == SEQ_FRESH),
    .load_val (k_lat - 1'b1),
    .dec      (mac_fire),
    .zero     (k_zero)
  );

  aixh_mxc_seq_cnt #(.W(TCNT_BITS)) u_tcnt (
    .clk      (aixh_core_clk2x),
    .rst      (aixh_core_rst),
    .load     (accept),
    .load_val (i_tcnt - 1'b1),
    .dec      (tile_end),
    .zero     (t_zero)
  );

  aixh_mxc_seq_cnt #(.W(4)) u_gcnt (
    .clk      (aixh_core_clk2x),
    .rst      (aixh_core_rst),
    .load     (drain_fire),
    .load_val (4'(GAP_LD)),
    .dec      (state == SEQ_GAP),
    .zero     (g_zero)
  );

  always_ff @(posedge aixh_core_clk2x) begin
    if (aixh_core_rst) begin
      state <= SEQ_IDLE;
      k_lat <= '0;
      tile  <= '0;
      mode  <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        SEQ_IDLE: begin
          if (i_start) begin
            if (legal) begin
              k_lat <= i_kcnt;
              mode  <= i_mode;
              tile  <= '0;
              state <= SEQ_FRESH;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SEQ_FRESH: state <= SEQ_MAC;
        SEQ_MAC: begin
          if (mac_fire && k_zero) state <= SEQ_DRAIN;
        end
        SEQ_DRAIN, SEQ_GAP: begin
          if (tile_end) begin
            if (t_zero) begin
              state <= SEQ_DONE;
            end else begin
              tile  <= tile + 1'b1;
              state <= SEQ_FRESH;
            end
          end else if (drain_fire) begin
            state <= SEQ_GAP;
          end
        end
        SEQ_DONE: state <= SEQ_IDLE;
        default:  state <= SEQ_IDLE;
      endcase
    end
  end

  assign o_ready      = (state == SEQ_IDLE);
  assign o_mac_afresh = (state == SEQ_FRESH);
  assign o_mac_enable = mac_fire;
  assign o_opnd_pop   = mac_fire;
  assign o_drain_req  = drain_fire;
  assign o_done       = (state == SEQ_DONE);
  assign o_err        = err;
  assign o_mac_mode   = mode;
  assign o_tile_idx   = tile;

endmodule

// File: tb/tb_aixh_mxc_mac_seq.sv
// Scoreboard bench for aixh_mxc_mac_seq (gap 4 and gap 0 instances).
// Stimulus queues expected command events; monitors pop and compare.
module tb_aixh_mxc_mac_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start1, vld, drdy;
  logic [15:0] kcnt, tcnt;
  logic [2:0]  mode;

  logic        rdy0, af0, en0, pop0, dr0, dn0, er0;
  logic [2:0]  mm0;
  logic [15:0] tile0;
  logic        rdy1, af1, en1, pop1, dr1, dn1, er1;
  logic [2:0]  mm1;
  logic [15:0] tile1;

  aixh_mxc_mac_seq u0 (
    .aixh_core_clk2x (clk),
    .aixh_core_rst   (rst),
    .i_start         (start),
    .i_kcnt          (kcnt),
    .i_tcnt          (tcnt),
    .i_mode          (mode),
    .i_opnd_vld      (vld),
    .i_drain_rdy     (drdy),
    .o_ready         (rdy0),
    .o_mac_afresh    (af0),
    .o_mac_enable    (en0),
    .o_opnd_pop      (pop0),
    .o_mac_mode      (mm0),
    .o_drain_req     (dr0),
    .o_tile_idx      (tile0),
    .o_done          (dn0),
    .o_err           (er0)
  );

  aixh_mxc_mac_seq #(.DRAIN_GAP(0)) u1 (
    .aixh_core_clk2x (clk),
    .aixh_core_rst   (rst),
    .i_start         (start1),
    .i_kcnt          (kcnt),
    .i_tcnt          (tcnt),
    .i_mode          (mode),
    .i_opnd_vld      (vld),
    .i_drain_rdy     (drdy),
    .o_ready         (rdy1),
    .o_mac_afresh    (af1),
    .o_mac_enable    (en1),
    .o_opnd_pop      (pop1),
    .o_mac_mode      (mm1),
    .o_drain_req     (dr1),
    .o_tile_idx      (tile1),
    .o_done          (dn1),
    .o_err           (er1)
  );

  typedef struct packed {
    logic [31:0] c;
    logic [5:0]  ev;
    logic [15:0] tile;
    logic        rdy;
  } rec_t;

  // ev = {err, done, drain, pop, enable, afresh}
  localparam logic [5:0] AF = 6'b000001;
  localparam logic [5:0] EN = 6'b000110;
  localparam logic [5:0] DR = 6'b001000;
  localparam logic [5:0] DN = 6'b010000;
  localparam logic [5:0] ER = 6'b100000;

  rec_t q0[$];
  rec_t q1[$];
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  bit   opat [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp_rec(input string n, input rec_t a, input rec_t e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got cyc=%0d ev=%b tile=%0d rdy=%b, want cyc=%0d ev=%b tile=%0d rdy=%b",
               n, a.c, a.ev, a.tile, a.rdy, e.c, e.ev, e.tile, e.rdy);
    end
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h", n, a, e);
    end
  endtask

  task automatic exp(input bit d, input int c, input logic [5:0] ev,
                     input logic [15:0] t, input logic r);
    rec_t e;
    e.c = 32'(c); e.ev = ev; e.tile = t; e.rdy = r;
    if (d) q1.push_back(e);
    else q0.push_back(e);
  endtask

  always @(negedge clk) if (mon_en) begin
    rec_t a;
    a.c = 32'(cyc); a.ev = {er0, dn0, dr0, pop0, en0, af0};
    a.tile = tile0; a.rdy = rdy0;
    if (a.ev != 6'b0) begin
      if (q0.size() == 0) cmp_rec("u0_unexpected", a, '0);
      else cmp_rec("u0_event", a, q0.pop_front());
    end
  end

  always @(negedge clk) if (mon_en) begin
    rec_t a;
    a.c = 32'(cyc); a.ev = {er1, dn1, dr1, pop1, en1, af1};
    a.tile = tile1; a.rdy = rdy1;
    if (a.ev != 6'b0) begin
      if (q1.size() == 0) cmp_rec("u1_unexpected", a, '0);
      else cmp_rec("u1_event", a, q1.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic go(input bit d, input int k, input int t,
                    input logic [2:0] m, output int s);
    kcnt = 16'(k); tcnt = 16'(t); mode = m;
    if (d) start1 = 1'b1;
    else start = 1'b1;
    s = cyc;
  endtask

  task automatic rel;
    tick();
    start = 1'b0; start1 = 1'b0;
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_ready"}, 32'(rdy0), 32'd1);
    chk({n, "_tile"}, 32'(tile0), 32'd0);
    chk({n, "_mode"}, 32'(mm0), 32'd0);
    chk({n, "_outs"}, 32'({af0, en0, pop0, dr0, dn0, er0}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; vld = 1'b1; drdy = 1'b1;
    kcnt = '0; tcnt = '0; mode = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk_reset("rst");
    chk("rst_u1_ready", 32'(rdy1), 32'd1);
    mon_en = 1'b1;

    // baseline: K=3 T=2 mode 100
    tick();
    go(0, 3, 2, 3'b100, s);
    exp(0, s + 1, AF, 0, 0);
    for (int i = 2; i <= 4; i++) exp(0, s + i, EN, 0, 0);
    exp(0, s + 5, DR, 0, 0);
    exp(0, s + 10, AF, 1, 0);
    for (int i = 11; i <= 13; i++) exp(0, s + i, EN, 1, 0);
    exp(0, s + 14, DR, 1, 0);
    exp(0, s + 19, DN, 1, 0);
    rel();
    wait_to(s + 3);
    chk("base_mode", 32'(mm0), 32'h4);
    wait_to(s + 20);
    chk("base_ready", 32'(rdy0), 32'd1);

    // operand stall: K=2, vld 0,1,0,0,1 from cycle 2
    vld = 1'b0;
    go(0, 2, 1, 3'b001, s);
    exp(0, s + 1, AF, 0, 0);
    exp(0, s + 3, EN, 0, 0);
    exp(0, s + 6, EN, 0, 0);
    exp(0, s + 7, DR, 0, 0);
    exp(0, s + 12, DN, 0, 0);
    rel();
    for (int i = 0; i < 5; i++) begin
      wait_to(s + 2 + i);
      vld = opat[i];
    end
    wait_to(s + 7);
    vld = 1'b1;
    wait_to(s + 13);

    // drain backpressure: rdy low for 3 DRAIN cycles
    go(0, 1, 1, 3'b110, s);
    exp(0, s + 1, AF, 0, 0);
    exp(0, s + 2, EN, 0, 0);
    exp(0, s + 6, DR, 0, 0);
    exp(0, s + 11, DN, 0, 0);
    rel();
    drdy = 1'b0;
    wait_to(s + 6);
    drdy = 1'b1;
    wait_to(s + 12);

    // rejects
    go(0, 0, 1, 3'b000, s);
    exp(0, s + 1, ER, 0, 1);
    rel(); tick();
    go(0, 1, 0, 3'b000, s);
    exp(0, s + 1, ER, 0, 1);
    rel(); tick();
    go(0, 1, 1, 3'b011, s);
    exp(0, s + 1, ER, 0, 1);
    rel(); tick();
    chk("reject_mode_kept", 32'(mm0), 32'h6);
    chk("reject_ready", 32'(rdy0), 32'd1);

    // start while busy is ignored
    go(0, 1, 1, 3'b001, s);
    exp(0, s + 1, AF, 0, 0);
    exp(0, s + 2, EN, 0, 0);
    exp(0, s + 3, DR, 0, 0);
    exp(0, s + 8, DN, 0, 0);
    rel();
    wait_to(s + 2);
    kcnt = 16'd5; mode = 3'b000; start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(s + 4);
    chk("busy_mode_kept", 32'(mm0), 32'h1);
    wait_to(s + 9);

    // zero-gap instance: drain directly followed by refresh
    go(1, 2, 2, 3'b010, s);
    exp(1, s + 1, AF, 0, 0);
    exp(1, s + 2, EN, 0, 0);
    exp(1, s + 3, EN, 0, 0);
    exp(1, s + 4, DR, 0, 0);
    exp(1, s + 5, AF, 1, 0);
    exp(1, s + 6, EN, 1, 0);
    exp(1, s + 7, EN, 1, 0);
    exp(1, s + 8, DR, 1, 0);
    exp(1, s + 9, DN, 1, 0);
    rel();
    wait_to(s + 10);
    chk("gap0_ready", 32'(rdy1), 32'd1);

    // reset during MAC aborts without drain or done
    go(0, 4, 1, 3'b101, s);
    exp(0, s + 1, AF, 0, 0);
    exp(0, s + 2, EN, 0, 0);
    exp(0, s + 3, EN, 0, 0);
    rel();
    wait_to(s + 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("midrst");
    go(0, 1, 1, 3'b100, s);
    exp(0, s + 1, AF, 0, 0);
    exp(0, s + 2, EN, 0, 0);
    exp(0, s + 3, DR, 0, 0);
    exp(0, s + 8, DN, 0, 0);
    rel();
    wait_to(s + 9);
    chk("post_rst_ready", 32'(rdy0), 32'd1);

    repeat (3) tick();
    while (q0.size() != 0) begin
      rec_t e;
      e = q0.pop_front();
      compared++; mismatched++;
      $display("FAIL u0_missing: got no event, want cyc=%0d ev=%b", e.c, e.ev);
    end
    while (q1.size() != 0) begin
      rec_t e;
      e = q1.pop_front();
      compared++; mismatched++;
      $display("FAIL u1_missing: got no event, want cyc=%0d ev=%b", e.c, e.ev);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
